// File: rtl/if_id_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage_if
// Purpose: bundles the fetch-stage control inputs, the instruction-memory
//          request/response pair and the IF/ID register outputs.
// Signals:
//   stall          fetch <- hazard unit, 0 = hold PC and IF/ID, 1 = advance
//   branch_taken   fetch <- EX, redirect request
//   branch_target  fetch <- EX, redirect PC
//   imem_addr      fetch -> imem, fetch address (= PC)
//   imem_req       fetch -> imem, fetch request valid
//   imem_rdata     fetch <- imem, instruction for imem_addr
//   imem_ready     fetch <- imem, imem_rdata valid
//   pc_2/pc4_2     fetch -> decode, PC and PC+4 of the IF/ID instruction
//   instr_2        fetch -> decode, instruction word
//   valid_2        fetch -> decode, 1 = real instruction, 0 = bubble
//   fetch_fault    fetch -> system, sticky misaligned-target fault
// Modports: master = fetch stage, slave = surrounding pipeline/memory.
// ----------------------------------------------------------------------------
interface if_id_fetch_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic [XLEN-1:0] imem_addr;
   logic            imem_req;
   logic [31:0]     imem_rdata;
   logic            imem_ready;
   logic [XLEN-1:0] pc_2;
   logic [XLEN-1:0] pc4_2;
   logic [31:0]     instr_2;
   logic            valid_2;
   logic            fetch_fault;

   modport master (
      input  stall, branch_taken, branch_target, imem_rdata, imem_ready,
      output imem_addr, imem_req, pc_2, pc4_2, instr_2, valid_2, fetch_fault
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_rdata, imem_ready,
      input  imem_addr, imem_req, pc_2, pc4_2, instr_2, valid_2, fetch_fault
   );
endinterface

// File: rtl/if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage
// Purpose: IF stage plus IF/ID pipeline register of a 5-stage RV32I pipeline.
//          Holds the PC, issues instruction fetches, captures returned
//          instructions into IF/ID, and handles load-use stalls (active-low
//          stall), EX-stage branch redirects and misaligned-target faults.
// Ports:
//   clk                clock, all state on posedge
//   rst                asynchronous active-high reset
//   fetch_bus          if_id_fetch_stage_if.master (control, imem, IF/ID)
//   o_perf_stall_cnt   stalled RUN cycles, saturating (FETCH_PERF_CNT_EN only)
//   o_perf_flush_cnt   accepted aligned redirects, saturating
//                      (FETCH_PERF_CNT_EN only)
// Configuration macro: FETCH_PERF_CNT_EN adds the performance counters.
// ----------------------------------------------------------------------------
module if_id_fetch_stage #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned     BOOT_CYCLES = 2,
   parameter logic [31:0]     NOP_INSTR   = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       rst,
   if_id_fetch_stage_if.master        fetch_bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                o_perf_stall_cnt,
   output logic [31:0]                o_perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [31:0]     r_boot_cnt;
   logic            w_boot_done;

   logic [XLEN-1:0] r_pc,      w_pc_d;
   logic [XLEN-1:0] r_pc_2,    w_pc_2_d;
   logic [XLEN-1:0] r_pc4_2,   w_pc4_2_d;
   logic [31:0]     r_instr_2, w_instr_2_d;
   logic            r_valid_2, w_valid_2_d;
   logic            r_fault,   w_fault_d;

   logic            w_run;
   logic            w_redirect;
   logic            w_misaligned;
   logic            w_redirect_ok;
   logic [XLEN-1:0] w_pc_plus4;
   logic            w_imem_req;

   assign w_run         = (r_state == StRun);
   assign w_redirect    = w_run & fetch_bus.branch_taken;
   assign w_misaligned  = w_redirect & (|fetch_bus.branch_target[1:0]);
   assign w_redirect_ok = w_redirect & ~w_misaligned;
   assign w_pc_plus4    = r_pc + XLEN'(4);  // wraps modulo 2^XLEN by construction
   assign w_boot_done   = (r_boot_cnt == BOOT_CYCLES - 1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StBoot;
         r_boot_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == StBoot) begin
            r_boot_cnt <= r_boot_cnt + 32'd1;
         end
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StBoot:  if (w_boot_done) w_state_next = StRun;
         StRun:   if (w_misaligned) w_state_next = StHalt;
         StHalt:  w_state_next = StHalt;  // only rst leaves HALT
         default: w_state_next = StBoot;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_imem_req = 1'b0;
      unique case (r_state)
         StRun:   w_imem_req = 1'b1;
         default: w_imem_req = 1'b0;
      endcase
   end

   // ---------------- PC and IF/ID next-state ----------------
   always_comb begin
      w_pc_d      = r_pc;
      w_pc_2_d    = r_pc_2;
      w_pc4_2_d   = r_pc4_2;
      w_instr_2_d = r_instr_2;
      w_valid_2_d = r_valid_2;
      w_fault_d   = r_fault;

      if (w_run) begin
         if (w_misaligned) begin
            w_fault_d   = 1'b1;
            w_pc_2_d    = r_pc;
            w_pc4_2_d   = w_pc_plus4;
            w_instr_2_d = NOP_INSTR;
            w_valid_2_d = 1'b0;
         end else if (w_redirect_ok) begin
            // Wins over a stall: the instruction sitting in ID is wrong-path.
            w_pc_d      = fetch_bus.branch_target;
            w_pc_2_d    = r_pc;
            w_pc4_2_d   = w_pc_plus4;
            w_instr_2_d = NOP_INSTR;
            w_valid_2_d = 1'b0;
         end else if (!fetch_bus.stall) begin
            // Load-use hold: everything keeps its value.
         end else if (!fetch_bus.imem_ready) begin
            w_pc_2_d    = r_pc;
            w_pc4_2_d   = w_pc_plus4;
            w_instr_2_d = NOP_INSTR;
            w_valid_2_d = 1'b0;
         end else begin
            w_pc_2_d    = r_pc;
            w_pc4_2_d   = w_pc_plus4;
            w_instr_2_d = fetch_bus.imem_rdata;
            w_valid_2_d = 1'b1;
            w_pc_d      = w_pc_plus4;
         end
      end else if (r_state == StHalt) begin
         w_instr_2_d = NOP_INSTR;
         w_valid_2_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_pc_2    <= '0;
         r_pc4_2   <= '0;
         r_instr_2 <= NOP_INSTR;
         r_valid_2 <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_pc      <= w_pc_d;
         r_pc_2    <= w_pc_2_d;
         r_pc4_2   <= w_pc4_2_d;
         r_instr_2 <= w_instr_2_d;
         r_valid_2 <= w_valid_2_d;
         r_fault   <= w_fault_d;
      end
   end

   assign fetch_bus.imem_addr   = r_pc;
   assign fetch_bus.imem_req    = w_imem_req;
   assign fetch_bus.pc_2        = r_pc_2;
   assign fetch_bus.pc4_2       = r_pc4_2;
   assign fetch_bus.instr_2     = r_instr_2;
   assign fetch_bus.valid_2     = r_valid_2;
   assign fetch_bus.fetch_fault = r_fault;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_flush_cnt;
   logic        w_stall_evt;

   assign w_stall_evt = w_run & ~fetch_bus.stall & ~fetch_bus.branch_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_stall_cnt <= '0;
         r_perf_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
         if (w_redirect_ok && (r_perf_flush_cnt != 32'hFFFF_FFFF)) begin
            r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
         end
      end
   end

   assign o_perf_stall_cnt = r_perf_stall_cnt;
   assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;

   if_id_fetch_stage_if #(.XLEN(32)) u_bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   if_id_fetch_stage #(
      .XLEN        (32),
      .RESET_PC    (32'h0000_0000),
      .BOOT_CYCLES (2),
      .NOP_INSTR   (NOP)
   ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_bus        (u_bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_perf_stall_cnt (perf_stall_cnt),
      .o_perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait instruction memory: word content is a function of its address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h00A0_0093;
   endfunction

   assign u_bus.imem_rdata = mem_word(u_bus.imem_addr);

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic [31:0] pc2;
      logic [31:0] pc4;
      logic        valid;
      logic        fault;
   } vec_t;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic [31:0] pc2;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
      logic        fault;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] tgt,
                               input logic rdy, input logic req, input logic [31:0] addr,
                               input logic [31:0] pc2, input logic [31:0] pc4,
                               input logic valid, input logic fault);
      vec_t v;
      v.stall = stall; v.br = br; v.tgt = tgt; v.rdy = rdy;
      v.req = req; v.addr = addr; v.pc2 = pc2; v.pc4 = pc4; v.valid = valid; v.fault = fault;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " req"},   {31'd0, u_bus.imem_req},    32'd0);
      chk({tag, " addr"},  u_bus.imem_addr,             32'd0);
      chk({tag, " pc2"},   u_bus.pc_2,                  32'd0);
      chk({tag, " pc4"},   u_bus.pc4_2,                 32'd0);
      chk({tag, " instr"}, u_bus.instr_2,               NOP);
      chk({tag, " valid"}, {31'd0, u_bus.valid_2},     32'd0);
      chk({tag, " fault"}, {31'd0, u_bus.fetch_fault}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, " perf_stall"}, perf_stall_cnt, 32'd0);
      chk({tag, " perf_flush"}, perf_flush_cnt, 32'd0);
`endif
   endtask

   // Drive one vector, queue its expectation, clock, then pop and compare.
   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         exp_t e;
         exp_t g;
         string nm;
         u_bus.stall         = tbl[i].stall;
         u_bus.branch_taken  = tbl[i].br;
         u_bus.branch_target = tbl[i].tgt;
         u_bus.imem_ready    = tbl[i].rdy;
         e.req   = tbl[i].req;
         e.addr  = tbl[i].addr;
         e.pc2   = tbl[i].pc2;
         e.pc4   = tbl[i].pc4;
         e.valid = tbl[i].valid;
         e.fault = tbl[i].fault;
         e.instr = tbl[i].valid ? mem_word(tbl[i].pc2) : NOP;
         sb.push_back(e);
         @(posedge clk);
         #1;
         nm = $sformatf("%s[%0d]", tag, i);
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: got empty expected entry", nm);
         end else begin
            g = sb.pop_front();
            chk({nm, " req"},   {31'd0, u_bus.imem_req},    {31'd0, g.req});
            chk({nm, " addr"},  u_bus.imem_addr,             g.addr);
            chk({nm, " pc2"},   u_bus.pc_2,                  g.pc2);
            chk({nm, " pc4"},   u_bus.pc4_2,                 g.pc4);
            chk({nm, " instr"}, u_bus.instr_2,               g.instr);
            chk({nm, " valid"}, {31'd0, u_bus.valid_2},     {31'd0, g.valid});
            chk({nm, " fault"}, {31'd0, u_bus.fetch_fault}, {31'd0, g.fault});
         end
      end
   endtask

   initial begin
      rst                 = 1'b1;
      u_bus.stall         = 1'b1;
      u_bus.branch_taken  = 1'b0;
      u_bus.branch_target = '0;
      u_bus.imem_ready    = 1'b1;
      #1;
      chk_reset("por");
      #11 rst = 1'b0;  // released between edges

      // stall br tgt rdy | req addr pc2 pc4 valid fault
      tbl.delete();
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0,   0, 0));
      tbl.push_back(mk(1, 1, 32'h40,       1, 1, 32'h0,        32'h0,        32'h0,   0, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h4,        32'h0,        32'h4,   1, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h8,        32'h4,        32'h8,   1, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'hC,        32'h8,        32'hC,   1, 0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC,        32'h8,        32'hC,   1, 0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC,        32'h8,        32'hC,   1, 0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC,        32'h8,        32'hC,   1, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h10,       32'hC,        32'h10,  1, 0));
      tbl.push_back(mk(0, 1, 32'h100,      1, 1, 32'h100,      32'h10,       32'h14,  0, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h104,      32'h100,      32'h104, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0,        0, 1, 32'h104,      32'h104,      32'h108, 0, 0));
      tbl.push_back(mk(1, 0, 32'h0,        0, 1, 32'h104,      32'h104,      32'h108, 0, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h108,      32'h104,      32'h108, 1, 0));
      tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 32'h108,      32'h10C, 0, 0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h0,        32'hFFFF_FFFC, 32'h0,   1, 0));
      tbl.push_back(mk(0, 1, 32'h102,      1, 0, 32'h0,        32'h0,        32'h4,   0, 1));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h4,   0, 1));
      tbl.push_back(mk(1, 1, 32'h200,      1, 0, 32'h0,        32'h0,        32'h4,   0, 1));
      run_table("main");

`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall count", perf_stall_cnt, 32'd3);
      chk("perf_flush count", perf_flush_cnt, 32'd2);
`endif

      // Reset out of HALT, asserted mid-cycle.
      u_bus.stall        = 1'b1;
      u_bus.branch_taken = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset("halt_rst");
      #2 rst = 1'b0;

      tbl.delete();
      tbl.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 0, 32'h0, 1, 1, 32'h4, 32'h0, 32'h4, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 1, 1, 32'h8, 32'h4, 32'h8, 1, 0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 1, 32'h8, 32'h4, 32'h8, 1, 0));
      run_table("restart");

      // Asynchronous reset mid-stream: outputs return immediately, no clock edge.
      #2 rst = 1'b1;
      #1 chk_reset("async_rst");
      #2 rst = 1'b0;

      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
